// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART TX/RX FIFOs.
package uart_fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_AFULL_LVL = DEF_DEPTH - 2;

    // Occupancy counter width: one extra bit so the count can reach DEPTH.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host/UART handshake bundle for the TX FIFO; master drives requests, slave is the FIFO.
interface uart_tx_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
);

    logic [DATA_W-1:0]         data_in;
    logic                      wr_en;
    logic                      rd_en;
    logic                      flush;
    logic                      clr_err;
    logic [DATA_W-1:0]         data_out;
    logic                      data_valid;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic [lvl_w(DEPTH)-1:0]   level;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output data_in, wr_en, rd_en, flush, clr_err,
        input  data_out, data_valid, full, empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en, flush, clr_err,
        output data_out, data_valid, full, empty, almost_full, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port array: synchronous write, registered read with enable.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read and write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmit FIFO with occupancy flags and sticky error reporting.
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic           clk_fifo_tx,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = lvl_w(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic is_full, is_empty;
    logic push_ok, pop_ok;
    logic ovf_evt, unf_evt;

    assign is_full  = (level_q == LvlW'(DEPTH));
    assign is_empty = (level_q == '0);

    // Flush suppresses every access, including error detection.
    assign pop_ok  = bus.rd_en && !is_empty && !bus.flush;
    assign push_ok = bus.wr_en && (!is_full || pop_ok) && !bus.flush;
    assign ovf_evt = bus.wr_en && !push_ok && !bus.flush;
    assign unf_evt = bus.rd_en && is_empty && !bus.flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        valid_d     = pop_ok;
        overflow_d  = (overflow_q && !bus.clr_err) || ovf_evt;
        underflow_d = (underflow_q && !bus.clr_err) || unf_evt;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + LvlW'(1);
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - LvlW'(1);
            end
        end
    end

    always_ff @(posedge clk_fifo_tx or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk_fifo_tx),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (bus.data_out)
    );

    assign bus.data_valid  = valid_q;
    assign bus.level       = level_q;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almost_full = (level_q >= LvlW'(AFULL_LVL));
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a reference queue model checked every cycle.
module tb_uart_tx_fifo;

    logic clk;
    logic rst_n;

    uart_tx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    uart_tx_fifo #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AFULL_LVL (14)
    ) dut (
        .clk_fifo_tx (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q [$];
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_over  = 1'b0;
    logic       m_under = 1'b0;

    int tb_lvl;
    int pushed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r,
                         input logic f, input logic c);
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
        bus.flush   = f;
        bus.clr_err = c;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"},  32'(bus.data_out),    32'h0);
        check({tag, "_valid"}, 32'(bus.data_valid),  32'h0);
        check({tag, "_level"}, 32'(bus.level),       32'h0);
        check({tag, "_full"},  32'(bus.full),        32'h0);
        check({tag, "_empty"}, 32'(bus.empty),       32'h1);
        check({tag, "_afull"}, 32'(bus.almost_full), 32'h0);
        check({tag, "_ovf"},   32'(bus.overflow),    32'h0);
        check({tag, "_unf"},   32'(bus.underflow),   32'h0);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update at each edge from the sampled inputs, then compare just after the edge.
    initial begin
        forever begin
            logic pop, push;
            @(posedge clk);
            if (!rst_n) begin
                m_q.delete();
                m_data  = 8'h00;
                m_valid = 1'b0;
                m_over  = 1'b0;
                m_under = 1'b0;
            end else begin
                pop  = bus.rd_en && (m_q.size() > 0) && !bus.flush;
                push = bus.wr_en && ((m_q.size() < 16) || pop) && !bus.flush;
                if (bus.clr_err) begin
                    m_over  = 1'b0;
                    m_under = 1'b0;
                end
                if (bus.flush) begin
                    m_q.delete();
                    m_valid = 1'b0;
                end else begin
                    m_valid = pop;
                    if (pop) m_data = m_q.pop_front();
                    if (push) m_q.push_back(bus.data_in);
                    if (bus.wr_en && !push) m_over = 1'b1;
                    if (bus.rd_en && !pop) m_under = 1'b1;
                end
            end
            #1;
            check("level", 32'(bus.level),       32'(m_q.size()));
            check("full",  32'(bus.full),        32'(m_q.size() == 16));
            check("empty", 32'(bus.empty),       32'(m_q.size() == 0));
            check("afull", 32'(bus.almost_full), 32'(m_q.size() >= 14));
            check("ovf",   32'(bus.overflow),    32'(m_over));
            check("unf",   32'(bus.underflow),   32'(m_under));
            check("valid", 32'(bus.data_valid),  32'(m_valid));
            check("dout",  32'(bus.data_out),    32'(m_data));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] saved;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill and overflow
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full",  32'(bus.full),  32'h1);
        check("fill_level", 32'(bus.level), 32'd16);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check("ovf_set",   32'(bus.overflow), 32'h1);
        check("ovf_level", 32'(bus.level),    32'd16);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(bus.overflow), 32'h0);

        // Full FIFO, simultaneous push/pop: oldest out, 0x77 queued last
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("sim_full_dout",  32'(bus.data_out), 32'h00);
        check("sim_full_level", 32'(bus.level),    32'd16);
        check("sim_full_ovf",   32'(bus.overflow), 32'h0);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drain_last",  32'(bus.data_out), 32'h77);
        check("drain_empty", 32'(bus.empty),    32'h1);

        // Underflow with data_out held at 0x5C
        drive(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("unf_set",   32'(bus.underflow),  32'h1);
        check("unf_valid", 32'(bus.data_valid), 32'h0);
        check("unf_dout",  32'(bus.data_out),   32'h5C);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("unf_clr", 32'(bus.underflow), 32'h0);

        // Empty FIFO, simultaneous push/pop: pop rejected
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        check("sim_empty_unf",   32'(bus.underflow), 32'h1);
        check("sim_empty_level", 32'(bus.level),     32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("sim_empty_dout", 32'(bus.data_out), 32'h11);

        // Wrap-around: 40 bytes, level held in 1..3
        pushed = 0;
        tb_lvl = 0;
        while (pushed < 2) begin
            drive(1'b1, 8'(8'h30 + pushed), 1'b0, 1'b0, 1'b0);
            pushed++;
            tb_lvl++;
        end
        while (pushed < 40) begin
            int r;
            r = $urandom_range(0, 2);
            if (r == 0 && tb_lvl < 3) begin
                drive(1'b1, 8'(8'h30 + pushed), 1'b0, 1'b0, 1'b0);
                pushed++;
                tb_lvl++;
            end else if (r == 1 && tb_lvl > 1) begin
                drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                tb_lvl--;
            end else begin
                drive(1'b1, 8'(8'h30 + pushed), 1'b1, 1'b0, 1'b0);
                pushed++;
            end
        end
        while (tb_lvl > 0) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            tb_lvl--;
        end
        check("wrap_last",  32'(bus.data_out), 32'h57);
        check("wrap_empty", 32'(bus.empty),    32'h1);

        // Flush at level 5
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        check("flush_pre_level", 32'(bus.level), 32'd5);
        saved = bus.data_out;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush_level", 32'(bus.level),    32'd0);
        check("flush_empty", 32'(bus.empty),    32'h1);
        check("flush_dout",  32'(bus.data_out), 32'(saved));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hE3, 1'b1, 1'b0, 1'b0);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("post_rst_dout", 32'(bus.data_out), 32'hA5);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
